mem_access_stage: RTL and testbench

- Memory-access stage of the 5-stage ARM pipeline; sits between the execute stage and the MEM/WB pipeline register.
- Performs loads and stores to data memory over a req/ack handshake with variable latency, and stalls upstream while an access is outstanding.
- Produces registered data-memory result, rd, link bit, writeback enable, CPSR flags and ALU write data for the MEM/WB register.

---
 rtl/mem_stage_pkg.sv | 14 +
 rtl/mem_access_stage_if.sv | 22 ++
 rtl/mem_byte_lane.sv | 31 +++
 rtl/mem_access_stage.sv | 162 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and constants for the memory-access stage
package mem_stage_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic [3:0] BE_WORD    = 4'hF;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam int         REG_ADDR_W = 4;
  localparam int         FLAGS_W    = 4;

endpackage

// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data-memory req/ack bus between the stage and memory
interface mem_access_stage_if;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/mem_byte_lane.sv
// rtl/mem_byte_lane.sv - store lane replication/byte enables and load lane extraction
module mem_byte_lane
  import mem_stage_pkg::*;
(
  input  logic        byte_acc,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] load_data
);

  always_comb begin
    wdata     = store_data;
    be        = BE_WORD;
    load_data = rdata;
    if (byte_acc) begin
      wdata = {4{store_data[7:0]}};
      be    = BE_BYTE0 << addr_lo;
      // Little-endian: lane 0 is rdata[7:0]
      case (addr_lo)
        2'd0:    load_data = {24'h0, rdata[7:0]};
        2'd1:    load_data = {24'h0, rdata[15:8]};
        2'd2:    load_data = {24'h0, rdata[23:16]};
        default: load_data = {24'h0, rdata[31:24]};
      endcase
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - ARM pipeline memory-access stage; MEM_ALIGN_CHECK_EN aborts misaligned word accesses
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  in_mem_read,
  input  logic                  in_mem_write,
  input  logic                  in_byte,
  input  logic [31:0]           in_addr,
  input  logic [31:0]           in_store_data,
  input  logic [31:0]           in_alu_result,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_link,
  input  logic                  in_wb_en,
  input  logic [FLAGS_W-1:0]    in_cpsr,
  output logic                  stall,
  mem_access_stage_if.master    mem,
  output logic                  out_valid,
  output logic [31:0]           out_data_mem,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_link,
  output logic                  out_wb_en,
  output logic [FLAGS_W-1:0]    out_cpsr,
  output logic [31:0]           out_write_data,
  output logic                  abort
);

  localparam logic [0:0] IDLE = ST_IDLE;
  localparam logic [0:0] BUSY = ST_BUSY;

  logic [0:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic                  pend;
  logic                  h_read, h_write, h_byte, h_abort;
  logic [31:0]           h_addr, h_store, h_alu;
  logic [REG_ADDR_W-1:0] h_rd;
  logic                  h_link, h_wb_en;
  logic [FLAGS_W-1:0]    h_cpsr;

  logic        busy, ack_done, tmo, accept, is_mem, misalign, quick;
  logic [31:0] lane_wdata, lane_load;
  logic [3:0]  lane_be;

  assign busy     = (state == BUSY);
  assign ack_done = busy && mem.mem_ack;
  assign tmo      = busy && !mem.mem_ack && (cnt == CNT_W'(TIMEOUT - 1));
  assign accept   = in_valid && (!busy || mem.mem_ack);
  assign is_mem   = in_mem_read || in_mem_write;
  assign stall    = busy && !mem.mem_ack;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = is_mem && !in_byte && (in_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // Ops that finish without a memory transaction
  assign quick = !is_mem || misalign;

  mem_byte_lane u_lane (
    .byte_acc   (h_byte),
    .addr_lo    (h_addr[1:0]),
    .store_data (h_store),
    .rdata      (mem.mem_rdata),
    .wdata      (lane_wdata),
    .be         (lane_be),
    .load_data  (lane_load)
  );

  assign mem.mem_req   = busy;
  assign mem.mem_we    = busy && h_write;
  assign mem.mem_addr  = busy ? {h_addr[31:2], 2'b00} : 32'h0;
  assign mem.mem_wdata = busy ? lane_wdata : 32'h0;
  assign mem.mem_be    = busy ? lane_be : 4'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      pend           <= 1'b0;
      h_read         <= 1'b0;
      h_write        <= 1'b0;
      h_byte         <= 1'b0;
      h_abort        <= 1'b0;
      h_addr         <= '0;
      h_store        <= '0;
      h_alu          <= '0;
      h_rd           <= '0;
      h_link         <= 1'b0;
      h_wb_en        <= 1'b0;
      h_cpsr         <= '0;
      out_valid      <= 1'b0;
      out_data_mem   <= '0;
      out_rd         <= '0;
      out_link       <= 1'b0;
      out_wb_en      <= 1'b0;
      out_cpsr       <= '0;
      out_write_data <= '0;
      abort          <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      abort     <= 1'b0;

      if (ack_done || tmo || (!busy && pend)) begin
        out_valid      <= 1'b1;
        out_data_mem   <= (ack_done && h_read) ? lane_load : 32'h0;
        out_rd         <= h_rd;
        out_link       <= h_link;
        out_wb_en      <= h_wb_en && !tmo && !(pend && h_abort);
        out_cpsr       <= h_cpsr;
        out_write_data <= h_alu;
        abort          <= tmo || (!busy && pend && h_abort);
      end else if (accept && quick) begin
        out_valid      <= 1'b1;
        out_data_mem   <= 32'h0;
        out_rd         <= in_rd;
        out_link       <= in_link;
        out_wb_en      <= in_wb_en && !misalign;
        out_cpsr       <= in_cpsr;
        out_write_data <= in_alu_result;
        abort          <= misalign;
      end

      if (accept) begin
        h_read  <= in_mem_read;
        h_write <= in_mem_write && !in_mem_read;
        h_byte  <= in_byte;
        h_abort <= misalign;
        h_addr  <= in_addr;
        h_store <= in_store_data;
        h_alu   <= in_alu_result;
        h_rd    <= in_rd;
        h_link  <= in_link;
        h_wb_en <= in_wb_en;
        h_cpsr  <= in_cpsr;
      end

      if (tmo) begin
        state <= IDLE;
        pend  <= 1'b0;
        cnt   <= '0;
      end else if (stall) begin
        cnt <= cnt + CNT_W'(1);
      end else if (accept) begin
        // A quick op arriving while the result slot is taken is parked for one cycle
        state <= quick ? IDLE : BUSY;
        pend  <= quick && (busy || pend);
        cnt   <= '0;
      end else begin
        state <= IDLE;
        pend  <= 1'b0;
        cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed vector bench for mem_access_stage
module tb_mem_access_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_mem_read, in_mem_write, in_byte, in_link, in_wb_en;
  logic [31:0] in_addr, in_store_data, in_alu_result;
  logic [3:0]  in_rd, in_cpsr;
  logic        stall, out_valid, out_link, out_wb_en, abort;
  logic [31:0] out_data_mem, out_write_data;
  logic [3:0]  out_rd, out_cpsr;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_stage_if mif ();

  mem_access_stage #(.TIMEOUT(15), .CNT_W(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_mem_read    (in_mem_read),
    .in_mem_write   (in_mem_write),
    .in_byte        (in_byte),
    .in_addr        (in_addr),
    .in_store_data  (in_store_data),
    .in_alu_result  (in_alu_result),
    .in_rd          (in_rd),
    .in_link        (in_link),
    .in_wb_en       (in_wb_en),
    .in_cpsr        (in_cpsr),
    .stall          (stall),
    .mem            (mif),
    .out_valid      (out_valid),
    .out_data_mem   (out_data_mem),
    .out_rd         (out_rd),
    .out_link       (out_link),
    .out_wb_en      (out_wb_en),
    .out_cpsr       (out_cpsr),
    .out_write_data (out_write_data),
    .abort          (abort)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd_en;
    logic        wr_en;
    logic        byte_acc;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] alu;
    logic [3:0]  rd;
    logic        link;
    logic        wb;
    logic [3:0]  cpsr;
    int          delay;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
    logic        e_we;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic rd_en, input logic wr_en, input logic byte_acc,
                        input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [31:0] alu, input logic [3:0] rd, input logic wb);
    in_valid      = 1'b1;
    in_mem_read   = rd_en;
    in_mem_write  = wr_en;
    in_byte       = byte_acc;
    in_addr       = addr;
    in_store_data = sdata;
    in_alu_result = alu;
    in_rd         = rd;
    in_link       = 1'b0;
    in_wb_en      = wb;
    in_cpsr       = 4'h0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string t;
    t = $sformatf("v%0d", idx);
    set_op(v.rd_en, v.wr_en, v.byte_acc, v.addr, v.sdata, v.alu, v.rd, v.wb);
    in_link = v.link;
    in_cpsr = v.cpsr;
    tick();
    in_valid = 1'b0;
    if (v.rd_en || v.wr_en) begin
      chk({t, " mem_req"}, 32'(mif.mem_req), 32'd1);
      chk({t, " mem_addr"}, mif.mem_addr, v.e_addr);
      chk({t, " mem_wdata"}, mif.mem_wdata, v.e_wdata);
      chk({t, " mem_be"}, 32'(mif.mem_be), 32'(v.e_be));
      chk({t, " mem_we"}, 32'(mif.mem_we), 32'(v.e_we));
      for (int i = 0; i < v.delay; i++) begin
        chk({t, " stall wait"}, 32'(stall), 32'd1);
        tick();
      end
      mif.mem_ack   = 1'b1;
      mif.mem_rdata = v.rdata;
      #1;
      chk({t, " stall ack"}, 32'(stall), 32'd0);
      tick();
      mif.mem_ack   = 1'b0;
      mif.mem_rdata = 32'h0;
      chk({t, " mem_req after"}, 32'(mif.mem_req), 32'd0);
    end else begin
      chk({t, " stall"}, 32'(stall), 32'd0);
    end
    chk({t, " out_valid"}, 32'(out_valid), 32'd1);
    chk({t, " out_data_mem"}, out_data_mem, v.e_data);
    chk({t, " out_write_data"}, out_write_data, v.alu);
    chk({t, " out_rd"}, 32'(out_rd), 32'(v.rd));
    chk({t, " out_wb_en"}, 32'(out_wb_en), 32'(v.wb));
    chk({t, " out_link"}, 32'(out_link), 32'(v.link));
    chk({t, " out_cpsr"}, 32'(out_cpsr), 32'(v.cpsr));
    tick();
    chk({t, " out_valid pulse"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int n_req;
    logic seen_abort;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1234, 4'd3, 1'b0, 1'b1, 4'h0, 0, 32'h0,
                32'h0, 32'h0, 4'h0, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'hCAFEF00D, 32'h100, 4'd2, 1'b0, 1'b1, 4'h4, 3, 32'hDEADBEEF,
                32'h100, 32'hCAFEF00D, 4'hF, 1'b0, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h203, 32'h1234565A, 32'h203, 4'd0, 1'b0, 1'b0, 4'h0, 1, 32'hFFFFFFFF,
                32'h200, 32'h5A5A5A5A, 4'h8, 1'b1, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 32'h202, 32'h0, 32'h202, 4'd5, 1'b0, 1'b1, 4'h2, 2, 32'h11223344,
                32'h200, 32'h0, 4'h4, 1'b0, 32'h22};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h304, 32'hA5A50001, 32'h304, 4'd0, 1'b0, 1'b0, 4'h8, 0, 32'h12345678,
                32'h304, 32'hA5A50001, 4'hF, 1'b1, 32'h0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h400, 32'h55555555, 32'h400, 4'd6, 1'b0, 1'b1, 4'h1, 1, 32'h0BADF00D,
                32'h400, 32'h55555555, 4'hF, 1'b0, 32'h0BADF00D};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 32'h013, 32'h000000C3, 32'h13, 4'd9, 1'b0, 1'b1, 4'h0, 0, 32'h80FFFFFF,
                32'h010, 32'hC3C3C3C3, 4'h8, 1'b0, 32'h80};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hFFFFFFFF, 4'd14, 1'b1, 1'b0, 4'hA, 0, 32'h0,
                32'h0, 32'h0, 4'h0, 1'b0, 32'h0};
    vecs[8] = '{1'b0, 1'b1, 1'b1, 32'h001, 32'h000000E7, 32'h1, 4'd1, 1'b0, 1'b0, 4'h0, 0, 32'h0,
                32'h0, 32'hE7E7E7E7, 4'h2, 1'b1, 32'h0};

    reset = 1'b1;
    set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0);
    in_valid      = 1'b0;
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = 32'h0;
    tick();
    tick();
    reset = 1'b0;

    chk("reset mem_req", 32'(mif.mem_req), 32'd0);
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset abort", 32'(abort), 32'd0);
    chk("reset out_data_mem", out_data_mem, 32'h0);
    chk("reset out_write_data", out_write_data, 32'h0);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Back-to-back loads: second presented in the ack cycle
    set_op(1'b1, 1'b0, 1'b0, 32'h500, 32'h0, 32'h50, 4'd1, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 32'h11111111;
    set_op(1'b1, 1'b0, 1'b0, 32'h600, 32'h0, 32'h60, 4'd2, 1'b1);
    tick();
    in_valid      = 1'b0;
    mif.mem_ack   = 1'b0;
    chk("b2b first valid", 32'(out_valid), 32'd1);
    chk("b2b first data", out_data_mem, 32'h11111111);
    chk("b2b first rd", 32'(out_rd), 32'd1);
    chk("b2b mem_req held", 32'(mif.mem_req), 32'd1);
    chk("b2b second addr", mif.mem_addr, 32'h600);
    tick();
    chk("b2b gap valid", 32'(out_valid), 32'd0);
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 32'h22222222;
    tick();
    mif.mem_ack   = 1'b0;
    chk("b2b second valid", 32'(out_valid), 32'd1);
    chk("b2b second data", out_data_mem, 32'h22222222);
    chk("b2b second rd", 32'(out_rd), 32'd2);
    chk("b2b mem_req drop", 32'(mif.mem_req), 32'd0);
    tick();

    // Non-memory op in the ack cycle: its result follows one edge after the load's
    set_op(1'b1, 1'b0, 1'b0, 32'h700, 32'h0, 32'h70, 4'd4, 1'b1);
    tick();
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 32'h0000A0A0;
    set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h77, 4'd7, 1'b1);
    tick();
    in_valid    = 1'b0;
    mif.mem_ack = 1'b0;
    chk("b2b nm load data", out_data_mem, 32'h0000A0A0);
    chk("b2b nm load wdata", out_write_data, 32'h70);
    chk("b2b nm mem_req", 32'(mif.mem_req), 32'd0);
    tick();
    chk("b2b nm valid", 32'(out_valid), 32'd1);
    chk("b2b nm wdata", out_write_data, 32'h77);
    chk("b2b nm rd", 32'(out_rd), 32'd7);
    chk("b2b nm data", out_data_mem, 32'h0);
    tick();

    // Timeout with no ack
    set_op(1'b1, 1'b0, 1'b0, 32'h800, 32'h0, 32'h80, 4'd8, 1'b1);
    tick();
    in_valid   = 1'b0;
    n_req      = 0;
    seen_abort = 1'b0;
    for (int i = 0; i < 40 && !seen_abort; i++) begin
      if (abort) seen_abort = 1'b1;
      else begin
        if (mif.mem_req) n_req++;
        tick();
      end
    end
    chk("tmo abort seen", 32'(seen_abort), 32'd1);
    chk("tmo req cycles", 32'(n_req), 32'd15);
    chk("tmo out_valid", 32'(out_valid), 32'd1);
    chk("tmo out_wb_en", 32'(out_wb_en), 32'd0);
    chk("tmo out_data_mem", out_data_mem, 32'h0);
    chk("tmo mem_req", 32'(mif.mem_req), 32'd0);
    set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h99, 4'd9, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("tmo abort pulse", 32'(abort), 32'd0);
    chk("tmo idle accept", out_write_data, 32'h99);
    chk("tmo idle valid", 32'(out_valid), 32'd1);
    tick();

    // Ack in the timeout cycle wins
    set_op(1'b1, 1'b0, 1'b0, 32'h900, 32'h0, 32'h90, 4'd10, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 32'h5555AAAA;
    tick();
    mif.mem_ack = 1'b0;
    chk("late ack valid", 32'(out_valid), 32'd1);
    chk("late ack abort", 32'(abort), 32'd0);
    chk("late ack data", out_data_mem, 32'h5555AAAA);
    chk("late ack wb_en", 32'(out_wb_en), 32'd1);
    tick();

    // Reset mid-access
    set_op(1'b1, 1'b0, 1'b0, 32'hA00, 32'h0, 32'hA0, 4'd11, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst busy mem_req", 32'(mif.mem_req), 32'd0);
    chk("rst busy valid", 32'(out_valid), 32'd0);
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 32'hFFFF0000;
    tick();
    mif.mem_ack = 1'b0;
    chk("rst stray ack valid", 32'(out_valid), 32'd0);
    chk("rst stray ack data", out_data_mem, 32'h0);
    tick();

    // Misaligned word load
    set_op(1'b1, 1'b0, 1'b0, 32'h102, 32'h0, 32'h102, 4'd12, 1'b1);
    tick();
    in_valid = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    chk("align mem_req", 32'(mif.mem_req), 32'd0);
    chk("align abort", 32'(abort), 32'd1);
    chk("align valid", 32'(out_valid), 32'd1);
    chk("align wb_en", 32'(out_wb_en), 32'd0);
`else
    chk("align mem_req", 32'(mif.mem_req), 32'd1);
    chk("align mem_addr", mif.mem_addr, 32'h100);
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 32'h01020304;
    tick();
    mif.mem_ack = 1'b0;
    chk("align data", out_data_mem, 32'h01020304);
    chk("align abort", 32'(abort), 32'd0);
`endif
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
